cp0_ctrl: RTL and testbench

- Coprocessor-0 controller for the 5-stage pipelined MIPS CPU.
- Holds the STATUS, CAUSE, EPC and EHBR registers and serves MFC0/MTC0 from the ID stage.
- Latches the external interrupt and decides when it is accepted, and executes ERET.
- Drives the datapath's force-jump pair (jump_en, jump_addr) and captures the datapath's ret_addr as EPC.

---
 rtl/cp0_pkg.sv | 25 ++
 rtl/cp0_ctrl_irq_sync.sv | 28 ++
 rtl/cp0_ctrl.sv | 118 +++++++++++
 tb/tb_cp0_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: operation codes, register numbers, bit positions and
// controller state encodings.
package cp0_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_MFC0 = 2'd1;
  localparam logic [1:0] OP_MTC0 = 2'd2;
  localparam logic [1:0] OP_ERET = 2'd3;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EHBR   = 5'd15;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_IP   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ISR  = 2'd2
  } cp0_state_e;

endpackage

// File: rtl/cp0_ctrl_irq_sync.sv
// Synchroniser for the asynchronous interrupt line followed by a rising-edge
// detector that emits a one-cycle pulse per new request.
module irq_sync #(
  parameter int IRQ_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  output logic irq_pulse
);

  logic [IRQ_SYNC-1:0] sync_q;
  logic                last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[IRQ_SYNC-2:0], ir_in};
      last_q <= sync_q[IRQ_SYNC-1];
    end
  end

  // A held level produces only one pulse; a fresh edge is needed to re-arm.
  assign irq_pulse = sync_q[IRQ_SYNC-1] & ~last_q;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: STATUS/CAUSE/EPC/EHBR registers, interrupt
// acceptance, ERET and the datapath force-jump redirect.
//
// state | meaning
// IDLE  | no interrupt outstanding
// PEND  | interrupt pending, waiting for IE & ~EXL & safe
// ISR   | handler running, waiting for ERET
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EHBR_RST = 32'h0000_0010,
  parameter int          IRQ_SYNC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic        ir_ack,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        safe,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        flush
);

  cp0_state_e  state_q, state_d;
  logic        ie_q, exl_q, pend_q;
  logic [31:0] epc_q, ehbr_q;
  logic        irq_pulse, is_eret, is_mtc0, accept;

  irq_sync #(.IRQ_SYNC(IRQ_SYNC)) u_irq_sync (
    .clk       (clk),
    .rst       (rst),
    .ir_in     (ir_in),
    .irq_pulse (irq_pulse)
  );

  assign is_eret = en && (oper == OP_ERET);
  assign is_mtc0 = en && (oper == OP_MTC0);
  // ERET wins over an accept in the same cycle; the interrupt stays pending.
  assign accept  = (state_q == ST_PEND) && ie_q && !exl_q && safe && !is_eret;

  always_comb begin
    state_d   = state_q;
    jump_en   = 1'b0;
    jump_addr = '0;
    ir_ack    = 1'b0;
    case (state_q)
      ST_IDLE: if (pend_q || irq_pulse) state_d = ST_PEND;
      ST_PEND: if (accept) state_d = ST_ISR;
      ST_ISR:  if (is_eret) state_d = pend_q ? ST_PEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (is_eret) begin
      jump_en   = 1'b1;
      jump_addr = epc_q;
    end else if (accept) begin
      jump_en   = 1'b1;
      jump_addr = ehbr_q;
      ir_ack    = 1'b1;
    end
  end

  assign flush = jump_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      pend_q  <= 1'b0;
      epc_q   <= '0;
      ehbr_q  <= {EHBR_RST[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      if (is_mtc0) begin
        case (addr_w)
          REG_STATUS: begin
            ie_q  <= data_w[STATUS_IE];
            exl_q <= data_w[STATUS_EXL];
          end
          REG_EPC:  epc_q  <= data_w;
          REG_EHBR: ehbr_q <= {data_w[31:2], 2'b00};
          default: ;
        endcase
      end
      // Later assignments override a coincident MTC0 to STATUS or EPC.
      if (accept) begin
        epc_q <= ret_addr;
        exl_q <= 1'b1;
      end else if (is_eret) begin
        exl_q <= 1'b0;
      end
      if (irq_pulse)   pend_q <= 1'b1;
      else if (accept) pend_q <= 1'b0;
    end
  end

  always_comb begin
    data_r = '0;
    case (addr_r)
      REG_STATUS: begin
        data_r[STATUS_IE]  = ie_q;
        data_r[STATUS_EXL] = exl_q;
      end
      REG_CAUSE: data_r[CAUSE_IP] = pend_q;
      REG_EPC:   data_r = epc_q;
      REG_EHBR:  data_r = ehbr_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: register access, interrupt capture and
// acceptance, stall hold, ERET and ERET/interrupt collision.
module tb_cp0_ctrl;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ir_in, ir_ack, en, safe, jump_en, flush;
  logic [1:0]  oper;
  logic [4:0]  addr_r, addr_w;
  logic [31:0] data_r, data_w, ret_addr, jump_addr;

  int tests_run = 0;
  int failed    = 0;

  // Architectural model of the visible CP0 state.
  logic [1:0]  m_status;
  logic [31:0] m_epc, m_ehbr;

  always #5 clk = ~clk;

  cp0_ctrl #(.EHBR_RST(32'h0000_0010), .IRQ_SYNC(2)) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .ir_ack(ir_ack), .en(en), .oper(oper),
    .addr_r(addr_r), .data_r(data_r), .addr_w(addr_w), .data_w(data_w),
    .ret_addr(ret_addr), .safe(safe), .jump_en(jump_en), .jump_addr(jump_addr),
    .flush(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; oper = OP_MTC0; addr_w = a; data_w = d;
    tick();
    en = 1'b0; oper = OP_NONE;
  endtask

  function automatic logic [31:0] exp_reg(input logic [4:0] a);
    case (a)
      5'd12:   return {30'd0, m_status};
      5'd14:   return m_epc;
      5'd15:   return m_ehbr;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; ir_in = 1'b0; en = 1'b0; oper = OP_NONE; safe = 1'b0;
    addr_r = 5'd0; addr_w = 5'd0; data_w = '0; ret_addr = '0;
    tick();
    tests_run++; if ({jump_en, flush, ir_ack} !== 3'b000) begin failed++; $display("FAIL rst_outputs got %b exp 000", {jump_en, flush, ir_ack}); end
    tests_run++; if (jump_addr !== 32'd0) begin failed++; $display("FAIL rst_jump_addr got %h exp 0", jump_addr); end
    tick();
    rst = 1'b0;
    m_status = 2'd0; m_epc = 32'd0; m_ehbr = 32'h10;
    for (int a = 12; a <= 15; a++) begin
      addr_r = 5'(a); #1;
      tests_run++; if (data_r !== exp_reg(5'(a))) begin failed++; $display("FAIL rst_reg%0d got %h exp %h", a, data_r, exp_reg(5'(a))); end
    end
    tick();
    en = 1'b1; oper = OP_MTC0; addr_w = REG_EPC; data_w = 32'h1234; addr_r = REG_EPC; #1;
    tests_run++; if (data_r !== 32'd0) begin failed++; $display("FAIL no_bypass got %h exp 0", data_r); end
    tick();
    en = 1'b0; oper = OP_NONE; m_epc = 32'h1234; #1;
    tests_run++; if (data_r !== 32'h1234) begin failed++; $display("FAIL epc_write got %h exp 1234", data_r); end
  endtask

  task automatic test_regs_random();
    logic [4:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 30; i++) begin
      a = 5'($urandom_range(10, 17));
      d = $urandom;
      addr_r = a;
      en = 1'b1; oper = OP_MTC0; addr_w = a; data_w = d; #1;
      tests_run++; if (data_r !== exp_reg(a)) begin failed++; $display("FAIL rnd_pre reg%0d got %h exp %h", a, data_r, exp_reg(a)); end
      tick();
      en = 1'b0; oper = OP_NONE;
      if (a == 5'd12) m_status = d[1:0];
      if (a == 5'd14) m_epc = d;
      if (a == 5'd15) m_ehbr = {d[31:2], 2'b00};
      #1;
      tests_run++; if (data_r !== exp_reg(a)) begin failed++; $display("FAIL rnd_post reg%0d got %h exp %h", a, data_r, exp_reg(a)); end
    end
    mtc0(REG_STATUS, 32'd0); m_status = 2'd0;
    mtc0(REG_EHBR, 32'h13);  m_ehbr = 32'h10;
    addr_r = REG_EHBR; #1;
    tests_run++; if (data_r !== 32'h10) begin failed++; $display("FAIL ehbr_mask got %h exp 10", data_r); end
  endtask

  task automatic test_basic_irq();
    mtc0(REG_STATUS, 32'd1); m_status = 2'd1;
    safe = 1'b1; ret_addr = 32'h40; ir_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (jump_en !== 1'b0) begin failed++; $display("FAIL irq_early cycle%0d got %b exp 0", c, jump_en); end
      tick();
    end
    #1;
    tests_run++; if ({jump_en, ir_ack, flush} !== 3'b111) begin failed++; $display("FAIL irq_accept got %b exp 111", {jump_en, ir_ack, flush}); end
    tests_run++; if (jump_addr !== m_ehbr) begin failed++; $display("FAIL irq_target got %h exp %h", jump_addr, m_ehbr); end
    ir_in = 1'b0;
    tick();
    m_epc = 32'h40; m_status = 2'd3;
    tests_run++; if ({jump_en, ir_ack} !== 2'b00) begin failed++; $display("FAIL irq_one_cycle got %b exp 00", {jump_en, ir_ack}); end
    addr_r = REG_EPC; #1;
    tests_run++; if (data_r !== m_epc) begin failed++; $display("FAIL irq_epc got %h exp %h", data_r, m_epc); end
    addr_r = REG_STATUS; #1;
    tests_run++; if (data_r !== 32'd3) begin failed++; $display("FAIL irq_status got %h exp 3", data_r); end
  endtask

  task automatic test_eret();
    en = 1'b1; oper = OP_ERET; #1;
    tests_run++; if ({jump_en, ir_ack} !== 2'b10) begin failed++; $display("FAIL eret_jump got %b exp 10", {jump_en, ir_ack}); end
    tests_run++; if (jump_addr !== m_epc) begin failed++; $display("FAIL eret_target got %h exp %h", jump_addr, m_epc); end
    tick();
    en = 1'b0; oper = OP_NONE; m_status = 2'd1;
    addr_r = REG_STATUS; #1;
    tests_run++; if (data_r !== 32'd1) begin failed++; $display("FAIL eret_status got %h exp 1", data_r); end
    tests_run++; if ({jump_en, jump_addr} !== 33'd0) begin failed++; $display("FAIL eret_after got %b/%h exp 0/0", jump_en, jump_addr); end
  endtask

  task automatic test_masked();
    logic [31:0] r;
    mtc0(REG_STATUS, 32'd0); m_status = 2'd0;
    r = {$urandom, 2'b00} & 32'hffff_fffc;
    ret_addr = r; safe = 1'b1; ir_in = 1'b1;
    repeat (3) tick();
    addr_r = REG_CAUSE;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (jump_en !== 1'b0 || data_r !== 32'h100) begin failed++; $display("FAIL masked_hold got %b/%h exp 0/100", jump_en, data_r); end
      tick();
    end
    en = 1'b1; oper = OP_MTC0; addr_w = REG_STATUS; data_w = 32'd1; #1;
    tests_run++; if (jump_en !== 1'b0) begin failed++; $display("FAIL masked_prewrite got %b exp 0", jump_en); end
    tick();
    en = 1'b0; oper = OP_NONE; #1;
    tests_run++; if (jump_en !== 1'b1 || jump_addr !== m_ehbr) begin failed++; $display("FAIL masked_accept got %b/%h exp 1/%h", jump_en, jump_addr, m_ehbr); end
    tick();
    m_epc = r; m_status = 2'd3;
    addr_r = REG_EPC; #1;
    tests_run++; if (data_r !== m_epc) begin failed++; $display("FAIL masked_epc got %h exp %h", data_r, m_epc); end
    en = 1'b1; oper = OP_ERET;
    tick();
    en = 1'b0; oper = OP_NONE; m_status = 2'd1;
    addr_r = REG_CAUSE;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++; if (jump_en !== 1'b0 || data_r !== 32'd0) begin failed++; $display("FAIL level_rearm got %b/%h exp 0/0", jump_en, data_r); end
      tick();
    end
    ir_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_stall();
    logic [31:0] r;
    int          n;
    r = $urandom & 32'hffff_fffc;
    n = int'($urandom_range(5, 9));
    ret_addr = r; safe = 1'b0; ir_in = 1'b1;
    repeat (3) tick();
    ir_in = 1'b0;
    for (int c = 0; c < n; c++) begin
      #1;
      tests_run++; if (jump_en !== 1'b0) begin failed++; $display("FAIL stall_hold cycle%0d got %b exp 0", c, jump_en); end
      tick();
    end
    safe = 1'b1;
    en = 1'b1; oper = OP_MTC0; addr_w = REG_STATUS; data_w = 32'd1; #1;
    tests_run++; if ({jump_en, ir_ack} !== 2'b11) begin failed++; $display("FAIL stall_release got %b exp 11", {jump_en, ir_ack}); end
    tick();
    en = 1'b0; oper = OP_NONE; m_epc = r; m_status = 2'd3;
    addr_r = REG_STATUS; #1;
    tests_run++; if (data_r !== 32'd3) begin failed++; $display("FAIL exl_override got %h exp 3", data_r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    r = $urandom & 32'hffff_fffc;
    safe = 1'b1; ir_in = 1'b1;
    repeat (3) tick();
    ir_in = 1'b0;
    addr_r = REG_CAUSE;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++; if (jump_en !== 1'b0 || data_r !== 32'h100) begin failed++; $display("FAIL isr_hold got %b/%h exp 0/100", jump_en, data_r); end
      tick();
    end
    ret_addr = r;
    en = 1'b1; oper = OP_ERET; #1;
    tests_run++; if ({jump_en, ir_ack} !== 2'b10 || jump_addr !== m_epc) begin failed++; $display("FAIL coll_eret got %b/%h exp 10/%h", {jump_en, ir_ack}, jump_addr, m_epc); end
    tick();
    en = 1'b1; oper = OP_MTC0; addr_w = REG_EPC; data_w = 32'hdead_beec; #1;
    tests_run++; if (ir_ack !== 1'b1 || jump_addr !== m_ehbr) begin failed++; $display("FAIL coll_accept got %b/%h exp 1/%h", ir_ack, jump_addr, m_ehbr); end
    tick();
    en = 1'b0; oper = OP_NONE; m_epc = r; m_status = 2'd3;
    addr_r = REG_EPC; #1;
    tests_run++; if (data_r !== m_epc) begin failed++; $display("FAIL epc_priority got %h exp %h", data_r, m_epc); end
    safe = 1'b0;
    en = 1'b1; oper = OP_ERET; #1;
    tests_run++; if (jump_en !== 1'b1 || jump_addr !== m_epc) begin failed++; $display("FAIL eret_unsafe got %b/%h exp 1/%h", jump_en, jump_addr, m_epc); end
    tick();
    en = 1'b0; oper = OP_NONE; m_status = 2'd1;
    addr_r = REG_STATUS; #1;
    tests_run++; if (data_r !== 32'd1) begin failed++; $display("FAIL final_status got %h exp 1", data_r); end
  endtask

  initial begin
    test_reset();
    test_regs_random();
    test_basic_irq();
    test_eret();
    test_masked();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
